// File: rtl/acc_mem_pkg.sv
// acc_mem_pkg: default sizes and signed helpers shared by the accumulator
package acc_mem_pkg;
  localparam int DEPTH_D = 10;
  localparam int DW_D = 16;
  localparam int AW_D = 32;
  localparam int CW_D = 16;
  localparam int MAXW = 64;
  function automatic logic signed [MAXW-1:0] sext_to_acc(input logic [MAXW-1:0] x, input int w);
    return $signed(x << (MAXW - w)) >>> (MAXW - w);
  endfunction
  function automatic logic signed [MAXW-1:0] sat_add(input logic signed [MAXW-1:0] a, input logic signed [MAXW-1:0] b, input int w);
    logic signed [MAXW-1:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction
endpackage

// File: rtl/acc_mem_sdp_ram.sv
// acc_mem_sdp_ram: N x AW simple dual-port RAM with registered read
module acc_mem_sdp_ram
  import acc_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int AW = AW_D
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [AW-1:0]    wdata,
  input  logic [DEPTH-1:0] raddr,
  output logic [AW-1:0]    rdata
);
  logic [AW-1:0] mem [2**DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/acc_mem_accumulator.sv
// acc_mem_accumulator: coherent pulse integrator; ACC_MEM_SATURATE_EN makes the accumulate add saturate
module acc_mem_accumulator
  import acc_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int DW = DW_D,
  parameter int AW = AW_D,
  parameter int CW = CW_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             trig_int,
  input  logic [DW-1:0]    din,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [AW-1:0]    rd_data
);
  localparam logic [DEPTH-1:0] LAST = '1;
  logic issuing, init_q, s1_v, s2_v, rd_live, start, finish, unused;
  logic [DEPTH-1:0] ptr, s1_addr, s2_addr;
  logic [DW-1:0] s1_din;
  logic [AW-1:0] s2_sum, q, rd_hold, ext, sum;
  logic signed [MAXW-1:0] ext_w;
  assign start = trig && !busy;
  assign finish = s2_v && s2_addr == LAST;
  assign ext_w = sext_to_acc(MAXW'(s1_din), DW);
  assign ext = ext_w[AW-1:0];
`ifdef ACC_MEM_SATURATE_EN
  logic signed [MAXW-1:0] sat_w;
  assign sat_w = sat_add(sext_to_acc(MAXW'(q), AW), ext_w, AW);
  assign sum = init_q ? ext : sat_w[AW-1:0];
  assign unused = ^{ext_w[MAXW-1:AW], sat_w[MAXW-1:AW]};
`else
  assign sum = init_q ? ext : q + ext;
  assign unused = ^ext_w[MAXW-1:AW];
`endif
  // RAM output is shared with the pipeline, so readout freezes on rd_hold while busy
  assign rd_data = rd_live ? q : rd_hold;
  acc_mem_sdp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(s2_v && !rst),
    .waddr(s2_addr),
    .wdata(s2_sum),
    .raddr(busy ? ptr : rd_addr),
    .rdata(q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      count <= '0;
      issuing <= 1'b0;
      ptr <= '0;
      init_q <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      rd_live <= 1'b0;
      rd_hold <= '0;
    end else begin
      done <= finish;
      rd_live <= !busy;
      rd_hold <= rd_data;
      s1_v <= issuing;
      s2_v <= s1_v;
      if (start) begin
        busy <= 1'b1;
        issuing <= 1'b1;
        ptr <= '0;
        init_q <= trig_int;
      end
      if (issuing) begin
        ptr <= ptr + 1'b1;
        if (ptr == LAST) issuing <= 1'b0;
      end
      if (finish) begin
        busy <= 1'b0;
        count <= init_q ? CW'(1) : (&count ? count : count + 1'b1);
      end
    end
  end
  always_ff @(posedge clk) begin
    s1_din <= din;
    s1_addr <= ptr;
    s2_addr <= s1_addr;
    s2_sum <= sum;
  end
endmodule

// File: tb/tb_acc_mem_accumulator.sv
// tb_acc_mem_accumulator: scoreboard bench for the pulse integrator
module tb_acc_mem_accumulator;
  localparam int DEPTH = 10;
  localparam int N = 2**DEPTH;
  localparam int DW = 16;
  localparam int AW = 18;
  localparam int CW = 16;
`ifdef ACC_MEM_SATURATE_EN
  localparam int OV = 131071;
`else
  localparam int OV = -98309;
`endif
  logic clk = 0, rst, trig, trig_int, busy, done, rd_req, rd_vld = 0, hold_chk = 0;
  logic [DW-1:0] din;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] rd_addr;
  logic [AW-1:0] rd_data, hold_exp;
  logic [CW-1:0] done_q [$];
  logic [AW-1:0] rd_q [$];
  int total = 0, bad = 0;
  acc_mem_accumulator #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .trig(trig), .trig_int(trig_int), .din(din),
    .busy(busy), .done(done), .count(count), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_vld <= rd_req;
  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_count", count, done_q.pop_front());
    end
    if (rd_vld) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else chk("rd_data", rd_data, rd_q.pop_front());
    end
  end
  task automatic rd(input int a, input int e);
    @(negedge clk);
    rd_addr = DEPTH'(a);
    rd_req = 1'b1;
    rd_q.push_back(AW'(e));
    hold_exp = AW'(e);
    hold_chk = 1'b1;
  endtask
  task automatic rd_end();
    @(negedge clk);
    rd_req = 1'b0;
  endtask
  // evt: 0 plain pass, 1 stray trig at T+100, 2 reset at T+500
  task automatic pass(input bit init, input bit ramp, input int dv, input int exp_cnt, input int evt);
    int got;
    got = -1;
    @(negedge clk);
    trig = 1'b1;
    trig_int = init;
    din = '0;
    if (evt != 2) done_q.push_back(CW'(exp_cnt));
    for (int j = 0; j < N + 10; j++) begin
      @(negedge clk);
      trig = (evt == 1 && j == 100);
      trig_int = 1'b1;
      din = (j < N) ? DW'(ramp ? -512 + j : dv) : '0;
      if (j == 0) chk("busy_start", busy, 1);
      if (j == 5 && hold_chk) chk("rd_hold", rd_data, hold_exp);
      if (done && got < 0) begin
        got = j;
        chk("busy_end", busy, 0);
      end
      if (evt == 2 && j == 500) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        hold_chk = 1'b0;
        return;
      end
    end
    chk("done_latency", got, N + 2);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    trig = 1'b0;
    trig_int = 1'b0;
    din = '0;
    rd_addr = '0;
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    pass(1, 0, 5, 1, 0);
    rd(0, 5); rd(511, 5); rd(1023, 5); rd_end();
    pass(0, 0, -3, 2, 0);
    for (int i = 0; i < N; i++) rd(i, 2);
    rd_end();
    pass(1, 1, 0, 1, 0);
    rd(0, -512); rd(1, -511); rd(1023, 511); rd_end();
    pass(0, 0, 1, 2, 1);
    rd(0, -511); rd(1023, 512); rd_end();
    pass(0, 0, 7, 0, 2);
    repeat (5) @(negedge clk);
    pass(1, 0, 32767, 1, 0);
    for (int c = 2; c <= 5; c++) pass(0, 0, 32767, c, 0);
    rd(0, OV); rd(512, OV); rd(1023, OV); rd_end();
    repeat (5) @(negedge clk);
    chk("done_q_empty", done_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
